auction_seq_collector: RTL
==========================

// Module: auction_seq_collector
// PURPOSE
//  Sequential bid-intake end of the auction datapath: accepts up to 2**N bids one
//  per cycle over a valid/ready stream, tracks the running maximum and its index,
//  and presents {winner, winning_bid} on a valid/ready result port.
//  It is the streaming counterpart of the combinational max-tree auction. It serves
//  sources that deliver bids serially instead of as one wide vector.
// PARAMETERS
//  N  2  log2 of maximum bidders per round; winner index width
//  W  2  bid width in bits, unsigned
// PORTS
//  clk           in   1  single clock, rising edge
//  rst           in   1  reset, asynchronous, active-high
//  bid_valid     in   1  bid present on bid
//  bid_ready     out  1  collector can accept a bid this cycle
//  bid           in   W  unsigned bid value
//  bid_last      in   1  qualifies bid as final bid of the round (early close)
//  result_valid  out  1  winner/winning_bid/bid_count valid
//  result_ready  in   1  downstream accepts result
//  winner        out  N  index (arrival order, 0-based) of winning bid
//  winning_bid   out  W  value of winning bid
//  bid_count     out  N+1  number of bids in the closed round (1..2**N)
// BEHAVIOUR
//  - Clock and reset: one clock; reset is asynchronous and active-high.
//  - Reset: state=COLLECT, idx=0, max=0, winner=0, winning_bid=0, bid_count=0.
//    Outputs after reset: bid_ready=1, result_valid=0.
//  - Reset wins over every other event. Asserting rst mid-round discards all
//    accepted bids. Asserting rst mid-result drops the pending result.
//  - State COLLECT: bid_ready=1, result_valid=0. A bid is accepted when
//    bid_valid&&bid_ready. On each accept:
//      * if idx==0 or bid > max (strict, unsigned): max<=bid, winner<=idx.
//      * Ties keep the earlier bid, so the lowest index wins.
//      * idx<=idx+1.
//  - Round close: the round closes on the accept where bid_last=1 or idx==2**N-1.
//    The close sets bid_count<=idx+1 and moves to RESULT. bid_last is ignored
//    unless bid_valid is high.
//  - State RESULT: bid_ready=0, result_valid=1.
//    * winner, winning_bid and bid_count are held stable until result_ready=1.
//    * On result_ready: go to COLLECT, idx<=0.
//    * result_valid drops the next cycle. No bid is accepted in the handshake cycle.
//  - Latency: result_valid rises exactly 1 cycle after the closing bid is accepted.
//    The minimum round for 2**N bids is 2**N+1 cycles, plus 1 cycle for the
//    result handshake.
//  - winning_bid/winner reflect the running max during COLLECT. They are only
//    meaningful while result_valid=1.
//  - Stalls: bid_valid may be low for any number of cycles mid-round; state is held.
//    result_ready may be high while in COLLECT; it is ignored there.
//  - Widths: idx is N+1 bits internally. The idx==2**N-1 compare prevents
//    overflow; an idx wrap is never observable.
// STRUCTURE
//  - Shared package/include: state encoding localparams ST_COLLECT, ST_RESULT.
//    It also holds localparam NB=2**N and the bid_count width N+1.
//  - One sub-module: auction_max_reg (W, N). Holds max/winner and performs the
//    strict-greater compare and update on an enable pulse plus a first-bid flag.
//    It reuses the same unsigned compare semantics as the combinational COMP.
//  - Top level: FSM, index counter, round-close logic, handshake outputs.
// TESTING  (N=2, W=2 unless noted)
//  1. Bids 1,3,2,0 back-to-back, result_ready=1
//     -> result_valid 1 cycle after 4th accept; winner=1, winning_bid=3, bid_count=4.
//  2. Bids 2,2,2,2 -> winner=0, winning_bid=2 (tie keeps lowest index).
//  3. Bids 0 then 1 with bid_last=1 -> winner=1, winning_bid=1, bid_count=2.
//     The next round starts at idx 0.
//  4. Close round with result_ready=0 for 5 cycles while bid_valid=1, bid=3:
//     -> outputs stable, bid_ready=0, no accept.
//     Then result_ready=1 -> a fresh round begins and the first bid is index 0.
//  5. Accept 2 bids (3,1), assert rst 1 cycle
//     -> all outputs 0, bid_ready=1.
//     New round 0,0,0,2 -> winner=3, winning_bid=2.
//  6. Random valid gaps and random result_ready, 1000 rounds
//     -> scoreboard matches the combinational auction on the collected bids.

Source files
------------

// File: rtl/auction_seq_collector_pkg.sv
// Shared types and constants for the streaming auction collector.
// Holds the round-size constants, the FSM state type and the unsigned bid compare.
package auction_seq_collector_pkg;

  localparam int AS_N  = 2;
  localparam int AS_W  = 2;
  localparam int NB    = 2 ** AS_N;
  localparam int CNT_W = AS_N + 1;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_RESULT  = 1'b1
  } state_t;

  // Same strict unsigned compare as the combinational max-tree comparator.
  function automatic logic bid_beats(input int unsigned challenger,
                                     input int unsigned incumbent);
    return challenger > incumbent;
  endfunction

endpackage

// File: rtl/auction_seq_collector_if.sv
// Bid-stream and result-port bundle for the auction collector.
// valid/ready: a transfer happens on a rising clk edge where valid && ready are both high.
interface auction_seq_if #(
  parameter int N = 2,
  parameter int W = 2
);
  logic         bid_valid;
  logic         bid_ready;
  logic [W-1:0] bid;
  logic         bid_last;
  logic         result_valid;
  logic         result_ready;
  logic [N-1:0] winner;
  logic [W-1:0] winning_bid;
  logic [N:0]   bid_count;

  modport master (
    output bid_valid, bid, bid_last, result_ready,
    input  bid_ready, result_valid, winner, winning_bid, bid_count
  );

  modport slave (
    input  bid_valid, bid, bid_last, result_ready,
    output bid_ready, result_valid, winner, winning_bid, bid_count
  );
endinterface

// File: rtl/auction_seq_collector_max_reg.sv
// Running-maximum register: keeps the largest bid seen so far and its arrival index.
// The first bid of a round always loads; later bids load only when strictly greater.
module auction_max_reg
  import auction_seq_collector_pkg::*;
#(
  parameter int W = AS_W,
  parameter int N = AS_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  input  logic         i_first,
  input  logic [W-1:0] i_bid,
  input  logic [N-1:0] i_idx,
  output logic [W-1:0] o_max,
  output logic [N-1:0] o_winner
);

  logic [W-1:0] r_max;
  logic [N-1:0] r_winner;
  logic         w_load;

  assign w_load = i_en && (i_first || bid_beats(int'(i_bid), int'(r_max)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_max    <= '0;
      r_winner <= '0;
    end else if (w_load) begin
      r_max    <= i_bid;
      r_winner <= i_idx;
    end
  end

  assign o_max    = r_max;
  assign o_winner = r_winner;

endmodule

// File: rtl/auction_seq_collector.sv
// Serial auction intake: collects up to 2**N bids, then offers {winner, winning_bid,
// bid_count} on the result port until downstream takes it.
module auction_seq_collector
  import auction_seq_collector_pkg::*;
#(
  parameter int N = AS_N,
  parameter int W = AS_W
) (
  input  logic         clk,
  input  logic         rst,
  auction_seq_if.slave bus,
  output state_t       o_state
);

  localparam int NB_L = 2 ** N;
  localparam logic [N:0] IDX_LAST = (N + 1)'(NB_L - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [N:0] r_idx;
  logic [N:0] r_bid_count;
  logic       w_accept;
  logic       w_close;
  logic       w_handshake;
  logic       w_bid_ready;
  logic       w_result_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_COLLECT;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_accept       = 1'b0;
    w_close        = 1'b0;
    w_handshake    = 1'b0;
    w_bid_ready    = 1'b0;
    w_result_valid = 1'b0;
    case (r_state)
      ST_COLLECT: begin
        w_bid_ready = 1'b1;
        w_accept    = bus.bid_valid;
        // bid_last only counts when it rides on an accepted bid.
        w_close     = w_accept && (bus.bid_last || (r_idx == IDX_LAST));
        if (w_close) w_state_nxt = ST_RESULT;
      end
      ST_RESULT: begin
        w_result_valid = 1'b1;
        w_handshake    = bus.result_ready;
        if (w_handshake) w_state_nxt = ST_COLLECT;
      end
      default: w_state_nxt = ST_COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx       <= '0;
      r_bid_count <= '0;
    end else begin
      if (w_handshake)   r_idx <= '0;
      else if (w_accept) r_idx <= r_idx + 1'b1;
      if (w_close)       r_bid_count <= r_idx + 1'b1;
    end
  end

  auction_max_reg #(
    .W (W),
    .N (N)
  ) u_max_reg (
    .clk      (clk),
    .rst      (rst),
    .i_en     (w_accept),
    .i_first  (r_idx == '0),
    .i_bid    (bus.bid),
    .i_idx    (r_idx[N-1:0]),
    .o_max    (bus.winning_bid),
    .o_winner (bus.winner)
  );

  assign bus.bid_ready    = w_bid_ready;
  assign bus.result_valid = w_result_valid;
  assign bus.bid_count    = r_bid_count;
  assign o_state          = r_state;

endmodule
